// File: rtl/scroll_sequencer.sv
// Message-window scroll controller: steps msg_ptr from the button or an auto-scroll divider
// and hands each new pointer to the memory reader over load_req/load_ack. Macro: SCROLL_DIR_EN.
module scroll_sequencer #(
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned SCROLL_DIV = 25000000,
  parameter int unsigned DIV_W      = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             auto_sel,
  input  logic             hold,
  input  logic             load_ack,
`ifdef SCROLL_DIR_EN
  input  logic             dir,
`endif
  output logic [PTR_W-1:0] msg_ptr,
  output logic             load_req,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StManual = 2'd1,
    StAuto   = 2'd2,
    StLoad   = 2'd3
  } state_e;

  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(MSG_LEN - 1);
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(SCROLL_DIV - 1);

  state_e           state_q;
  logic             btn_q;
  logic             pending_q;
  logic [DIV_W-1:0] div_q;

  logic             step_btn;
  logic             tick;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    step_btn = button & ~btn_q;
    tick     = (state_q == StAuto) && !hold && (div_q == DivLast);
  end

  always_comb begin
    ptr_next = (msg_ptr == PtrLast) ? '0 : msg_ptr + PTR_W'(1);
`ifdef SCROLL_DIR_EN
    if (dir) begin
      ptr_next = (msg_ptr == '0) ? PtrLast : msg_ptr - PTR_W'(1);
    end
`endif
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StInit;
      msg_ptr   <= '0;
      load_req  <= 1'b0;
      div_q     <= '0;
      pending_q <= 1'b0;
      btn_q     <= 1'b1;  // a button held through reset must not count as a press
    end else begin
      btn_q <= button;
      unique case (state_q)
        StInit: begin
          msg_ptr  <= '0;
          load_req <= 1'b1;
          div_q    <= '0;
          state_q  <= StLoad;
        end
        StManual: begin
          if (step_btn) begin
            msg_ptr  <= ptr_next;
            load_req <= 1'b1;
            state_q  <= StLoad;
          end else if (auto_sel) begin
            div_q   <= '0;
            state_q <= StAuto;
          end
        end
        StAuto: begin
          if (step_btn || tick) begin
            msg_ptr  <= ptr_next;
            load_req <= 1'b1;
            div_q    <= '0;
            state_q  <= StLoad;
          end else if (!auto_sel) begin
            div_q   <= '0;
            state_q <= StManual;
          end else if (!hold) begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        StLoad: begin
          if (load_ack) begin
            // The ack consumes at most one queued step; a press on the ack edge itself is dropped.
            pending_q <= 1'b0;
            if (pending_q) begin
              msg_ptr <= ptr_next;
            end else begin
              load_req <= 1'b0;
              state_q  <= auto_sel ? StAuto : StManual;
            end
          end else if (step_btn || tick) begin
            pending_q <= 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer: a vector table for the basic flow, then hand-written
// sequences for wrap-around, auto-scroll timing, hold, queued steps and reset corners.
module tb_scroll_sequencer;

  logic       clk = 1'b0;
  logic       reset, button, auto_sel, hold, load_ack;
  logic [3:0] msg_ptr;
  logic       load_req;
  logic [1:0] state;
`ifdef SCROLL_DIR_EN
  logic       dir;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scroll_sequencer #(
    .MSG_LEN   (16),
    .PTR_W     (4),
    .SCROLL_DIV(4),
    .DIV_W     (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .button  (button),
    .auto_sel(auto_sel),
    .hold    (hold),
    .load_ack(load_ack),
`ifdef SCROLL_DIR_EN
    .dir     (dir),
`endif
    .msg_ptr (msg_ptr),
    .load_req(load_req),
    .state   (state)
  );

  typedef struct {
    logic       button;
    logic       auto_sel;
    logic       hold;
    logic       load_ack;
    logic [3:0] exp_ptr;
    logic       exp_req;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] p, input logic r,
                           input logic [1:0] s);
    check({name, ".ptr"}, 32'(msg_ptr), 32'(p));
    check({name, ".req"}, 32'(load_req), 32'(r));
    check({name, ".state"}, 32'(state), 32'(s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] p0;
    int         req_rises;
    logic       req_prev;

    //            btn   auto  hold  ack   ptr  req   state
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd3};  // INIT -> LOAD
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd1};  // ack -> MANUAL
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 2'd3};  // press
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 2'd3};  // held, no edge
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 2'd2};  // -> AUTO, div 0
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 2'd2};  // div 3
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 2'd3};  // tick
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 2'd1};  // auto off -> MANUAL

    button = 1'b0; auto_sel = 1'b0; hold = 1'b0; load_ack = 1'b0;
`ifdef SCROLL_DIR_EN
    dir = 1'b0;
`endif
    #2;
    do_reset();
    check_out("reset", 4'd0, 1'b0, 2'd0);

    for (int i = 0; i < 13; i++) begin
      button   = vecs[i].button;
      auto_sel = vecs[i].auto_sel;
      hold     = vecs[i].hold;
      load_ack = vecs[i].load_ack;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_ptr, vecs[i].exp_req, vecs[i].exp_state);
    end

    // Manual wrap-around: 17 presses, ack after 3 cycles each.
    button = 1'b0; auto_sel = 1'b0; hold = 1'b0; load_ack = 1'b1;
    do_reset();
    step();
    step();
    check_out("man_start", 4'd0, 1'b0, 2'd1);
    load_ack  = 1'b0;
    req_rises = 0;
    req_prev  = load_req;
    for (int i = 0; i < 17; i++) begin
      button = 1'b1;
      step();
      if (load_req && !req_prev) req_rises++;
      req_prev = load_req;
      button = 1'b0;
      for (int k = 0; k < 3; k++) step();
      load_ack = 1'b1;
      step();
      req_prev = load_req;
      load_ack = 1'b0;
      check_out($sformatf("man%0d", i), 4'((i + 1) % 16), 1'b0, 2'd1);
    end
    check("man_req_count", 32'(req_rises), 32'd17);

    // Auto-scroll with immediate ack: one step every 5 cycles.
    load_ack = 1'b1;
    auto_sel = 1'b1;
    step();
    p0 = msg_ptr;
    check("auto_enter", 32'(state), 32'd2);
    for (int k = 0; k < 4; k++) step();
    check_out("auto_first", p0 + 4'd1, 1'b1, 2'd3);
    for (int k = 0; k < 4; k++) step();
    check("auto_gap", 32'(msg_ptr), 32'(p0 + 4'd1));
    step();
    check_out("auto_second", p0 + 4'd2, 1'b1, 2'd3);

    // Hold freezes the divider at 2; release needs only two more cycles.
    step();
    step();
    step();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check_out("hold_frozen", p0 + 4'd2, 1'b0, 2'd2);
    hold = 1'b0;
    step();
    check_out("hold_rel1", p0 + 4'd2, 1'b0, 2'd2);
    step();
    check_out("hold_rel2", p0 + 4'd3, 1'b1, 2'd3);

    // Queued steps while ack is withheld: only one extra step survives.
    auto_sel = 1'b0;
    step();
    check("q_manual", 32'(state), 32'd1);
    load_ack = 1'b0;
    p0 = msg_ptr;
    button = 1'b1;
    step();
    button = 1'b0;
    for (int k = 0; k < 20; k++) begin
      button = (k == 2 || k == 6 || k == 10);
      step();
    end
    button = 1'b0;
    check_out("q_wait", p0 + 4'd1, 1'b1, 2'd3);
    load_ack = 1'b1;
    step();
    check_out("q_ack1", p0 + 4'd2, 1'b1, 2'd3);
    step();
    check_out("q_ack2", p0 + 4'd2, 1'b0, 2'd1);

    // Button held through reset gives no step.
    button = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    button = 1'b0;
    step();
    step();
    check_out("btn_reset", 4'd0, 1'b0, 2'd1);

    // Reset abandons an outstanding request.
    load_ack = 1'b0;
    button = 1'b1;
    step();
    button = 1'b0;
    check_out("abandon_pre", 4'd1, 1'b1, 2'd3);
    do_reset();
    check_out("abandon", 4'd0, 1'b0, 2'd0);

`ifdef SCROLL_DIR_EN
    load_ack = 1'b1;
    step();
    step();
    dir = 1'b1;
    button = 1'b1;
    step();
    button = 1'b0;
    check("dir_wrap", 32'(msg_ptr), 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
- Controller that sequences message rotation for the four-digit seven-segment display.
- Produces the message window start pointer, either stepped by the debounced push-button (manual) or by an internal divided-clock timer (auto-scroll).
- Each pointer change is handed to the message-memory reader over a req/ack handshake, so the reader reloads the four anode characters.
- Sits between the anti-bounce stages and the memory reader. Replaces the free-running button counter.

Parameters:
- MSG_LEN, 16: number of characters in the message; pointer wraps at MSG_LEN-1; any value 2..2**PTR_W.
- PTR_W, 4: width of msg_ptr.
- SCROLL_DIV, 25000000: clk cycles per auto-scroll step; must be >= 2.
- DIV_W, 25: width of the divider counter; must hold SCROLL_DIV-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high, from the reset anti-bounce stage.
- button  input  1  debounced button level; rising edge = one step request.
- auto_sel  input  1  level; 1 = auto-scroll mode, 0 = manual mode.
- hold  input  1  level; 1 freezes the auto-scroll timer (button steps still accepted).
- load_ack  input  1  reader has latched msg_ptr; sampled only in LOAD.
- msg_ptr  output  PTR_W  current window start index.
- load_req  output  1  high while a new msg_ptr awaits acknowledgement.
- state  output  2  FSM state: INIT=0, MANUAL=1, AUTO=2, LOAD=3.

Behaviour:
- Reset (clk edge with reset=1) sets:
  - msg_ptr=0, load_req=0, state=INIT, divider=0, pending=0.
  - btn_q=1, so a button held through reset does not generate a step.
- Edge detect: btn_q <= button every cycle. step_btn = button & ~btn_q.
- Divider:
  - Counts only in AUTO with hold=0. Holds its value while hold=1.
  - tick = (div==SCROLL_DIV-1) in AUTO with hold=0; on tick, div wraps to 0.
  - Cleared on any exit from AUTO and on every step_btn in AUTO.
- Pointer increment: msg_ptr==MSG_LEN-1 -> 0, else +1. No other arithmetic on msg_ptr.
- INIT: next cycle -> LOAD with msg_ptr=0 and load_req=1. This forces the initial character fetch.
- MANUAL:
  - step_btn: increment msg_ptr, set load_req=1, -> LOAD.
  - Else if auto_sel=1: -> AUTO (div=0).
- AUTO:
  - step_btn or tick: increment, load_req=1, -> LOAD. Simultaneous step_btn and tick count as a single step.
  - Else if auto_sel=0: -> MANUAL.
- LOAD:
  - msg_ptr is stable and load_req=1.
  - step_btn or tick in this state sets pending=1. pending saturates at 1; further events are dropped.
  - load_ack=1 with pending=0: load_req=0 next cycle, -> AUTO if auto_sel=1 else MANUAL.
  - load_ack=1 with pending=1: load_req stays 1, msg_ptr increments once, pending=0, remain in LOAD.
  - load_ack may be high in the same cycle load_req first rises.
  - No timeout; the FSM waits for ack indefinitely.
- Latency: step event sampled at edge N gives the new msg_ptr and load_req=1 after edge N+1 (one cycle).
- Mode change during LOAD takes effect only on exit from LOAD.
- reset mid-handshake: load_req drops in the same edge and the FSM restarts at INIT. The reader must tolerate an abandoned request.

Optional Feature:
- Macro: SCROLL_DIR_EN.
- Defined:
  - Adds input port dir (1 bit).
  - dir=1 makes every step decrement, wrapping 0 -> MSG_LEN-1.
  - dir is sampled on the cycle of the step; a pending step in LOAD uses dir at ack time.
- Undefined: no dir port; always increment.

Test Plan:
- Reset, then load_ack tied 1 -> state INIT -> LOAD -> MANUAL; msg_ptr=0; load_req high exactly one cycle.
- MANUAL, MSG_LEN=16, 17 button pulses with ack after 3 cycles each -> msg_ptr goes 1..15 then 0 then 1; one load_req per pulse.
- AUTO, SCROLL_DIV=4, ack immediate -> msg_ptr increments every 5 cycles (4 divider + 1 LOAD). hold=1 for 10 cycles -> no change; release -> counting resumes from the frozen div value.
- LOAD with ack withheld 20 cycles, 3 button pulses -> msg_ptr +1 on ack and exactly one extra step (total +2 over the pre-LOAD value); excess pulses dropped.
- Button held high across reset, released after 5 cycles -> no step. Reset asserted while load_req=1 -> load_req=0 next edge; msg_ptr=0.
- SCROLL_DIR_EN defined, dir=1, msg_ptr=0, one pulse -> msg_ptr=15.
